dfh_scratch_walker: RTL

Hardware sequencer that walks a Device Feature Header (DFH) chain over a single-outstanding CSR (MMIO) master port. For every feature whose 128-bit GUID appears in a compile-time table, it writes a test pattern to that feature's scratch register and reads it back. It sits between the PF/VF access test harness (or a host-visible trigger) and the CSR fabric of one PF/VF, replacing host-driven scratch sweeps with an autonomous, repeatable check.

---
 rtl/dfh_scratch_walker.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dfh_scratch_walker.sv
// Walks a DFH chain over a single-outstanding CSR master and runs a scratch write/readback
// on every feature whose GUID is in GUID_TABLE. Define DFH_WALK_TIMEOUT_EN for the response watchdog.
module dfh_scratch_walker #(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned NUM_GUIDS    = 8,
  parameter logic [NUM_GUIDS*128-1:0] GUID_TABLE    = '0,
  parameter logic [NUM_GUIDS*16-1:0]  SCRATCH_TABLE = '0,
  parameter int unsigned MAX_FEATURES = 32,
  parameter logic [63:0] PATTERN      = 64'h5A5A_0000_A5A5_0000,
  parameter int unsigned TIMEOUT_CYC  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        err_code,
  output logic [ADDR_W-1:0] err_addr,
  output logic [5:0]        match_cnt,
  output logic [5:0]        feat_cnt,
  output logic              csr_req_valid,
  input  logic              csr_req_ready,
  output logic              csr_req_write,
  output logic [ADDR_W-1:0] csr_req_addr,
  output logic [63:0]       csr_req_wdata,
  input  logic              csr_rsp_valid,
  input  logic [63:0]       csr_rsp_data
);

  localparam int unsigned OFF_W = 24;
  localparam int unsigned SUM_W = ((ADDR_W > OFF_W) ? ADDR_W : OFF_W) + 1;

  typedef enum logic [3:0] {
    IDLE, RD_DFH, RD_GL, RD_GH, LOOKUP, WR_SCR, RD_SCR, CHECK, NEXT, FIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d, scr_addr_q, scr_addr_d;
  logic [OFF_W-1:0]    next_off_q, next_off_d;
  logic                eol_q, eol_d, rd_pend_q, rd_pend_d;
  logic [63:0]         guid_l_q, guid_l_d, guid_h_q, guid_h_d, rdback_q, rdback_d;
  logic                busy_d, done_d, pass_d;
  logic [2:0]          err_code_d;
  logic [ADDR_W-1:0]   err_addr_d, req_addr_d, req_addr_c;
  logic [5:0]          match_cnt_d, feat_cnt_d;
  logic                req_valid_d, req_write_d;
  logic [63:0]         req_wdata_d;
  logic                fin_c, hit_c, ovf_c;
  logic [15:0]         scr_off_c;
  logic [SUM_W-1:0]    sum_c;

`ifdef DFH_WALK_TIMEOUT_EN
  logic [15:0]         tmo_q, tmo_d;
`else
  logic                tmo_unused;
  assign tmo_unused = ^TIMEOUT_CYC;
`endif

  // GUID table search; iterating downward leaves the lowest matching index
  always_comb begin
    hit_c     = 1'b0;
    scr_off_c = '0;
    for (int i = int'(NUM_GUIDS) - 1; i >= 0; i--) begin
      if ({guid_h_q, guid_l_q} == GUID_TABLE[128*i +: 128]) begin
        hit_c     = 1'b1;
        scr_off_c = SCRATCH_TABLE[16*i +: 16];
      end
    end
  end

  assign sum_c = SUM_W'(cur_q) + SUM_W'(next_off_q);
  assign ovf_c = |sum_c[SUM_W-1:ADDR_W];

  always_comb begin
    case (state_q)
      RD_DFH:  req_addr_c = cur_q;
      RD_GL:   req_addr_c = cur_q + ADDR_W'(8);
      RD_GH:   req_addr_c = cur_q + ADDR_W'(16);
      default: req_addr_c = scr_addr_q;
    endcase
  end

  // Next-state and next register values
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    scr_addr_d  = scr_addr_q;
    next_off_d  = next_off_q;
    eol_d       = eol_q;
    rd_pend_d   = rd_pend_q;
    guid_l_d    = guid_l_q;
    guid_h_d    = guid_h_q;
    rdback_d    = rdback_q;
    busy_d      = busy;
    done_d      = 1'b0;
    pass_d      = pass;
    err_code_d  = err_code;
    err_addr_d  = err_addr;
    match_cnt_d = match_cnt;
    feat_cnt_d  = feat_cnt;
    req_valid_d = csr_req_valid;
    req_write_d = csr_req_write;
    req_addr_d  = csr_req_addr;
    req_wdata_d = csr_req_wdata;
    fin_c       = 1'b0;
`ifdef DFH_WALK_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d       = base_addr;
          match_cnt_d = '0;
          feat_cnt_d  = '0;
          err_code_d  = '0;
          err_addr_d  = '0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          state_d     = RD_DFH;
        end
      end
      RD_DFH, RD_GL, RD_GH, WR_SCR, RD_SCR: begin
        if (!csr_req_valid && !rd_pend_q) begin
          req_valid_d = 1'b1;
          req_write_d = (state_q == WR_SCR);
          req_addr_d  = {req_addr_c[ADDR_W-1:3], 3'b000};
          if (state_q == WR_SCR) req_wdata_d = PATTERN ^ {58'b0, feat_cnt};
        end else if (csr_req_valid && csr_req_ready) begin
          req_valid_d = 1'b0;
          if (state_q == WR_SCR) state_d = RD_SCR;
          else rd_pend_d = 1'b1;
        end else if (rd_pend_q && csr_rsp_valid) begin
          rd_pend_d = 1'b0;
          case (state_q)
            RD_DFH: begin
              next_off_d = csr_rsp_data[39:16];
              eol_d      = csr_rsp_data[40];
              feat_cnt_d = (feat_cnt == 6'd63) ? feat_cnt : feat_cnt + 6'd1;
              state_d    = RD_GL;
            end
            RD_GL:   begin guid_l_d = csr_rsp_data; state_d = RD_GH;  end
            RD_GH:   begin guid_h_d = csr_rsp_data; state_d = LOOKUP; end
            default: begin rdback_d = csr_rsp_data; state_d = CHECK;  end
          endcase
        end
      end
      LOOKUP: begin
        if (hit_c) begin
          scr_addr_d = cur_q + ADDR_W'(scr_off_c);
          state_d    = WR_SCR;
        end else begin
          state_d = NEXT;
        end
      end
      CHECK: begin
        if (rdback_q == csr_req_wdata) begin
          match_cnt_d = (match_cnt == 6'd63) ? match_cnt : match_cnt + 6'd1;
          state_d     = NEXT;
        end else begin
          err_code_d = 3'd1;
          err_addr_d = scr_addr_q;
          fin_c      = 1'b1;
        end
      end
      NEXT: begin
        if (eol_q || (next_off_q == '0)) begin
          fin_c = 1'b1;
        end else if (ovf_c) begin
          err_code_d = 3'd3;
          err_addr_d = cur_q;
          fin_c      = 1'b1;
        end else if (32'(feat_cnt) == MAX_FEATURES) begin
          err_code_d = 3'd2;
          err_addr_d = cur_q;
          fin_c      = 1'b1;
        end else begin
          cur_d   = sum_c[ADDR_W-1:0];
          state_d = RD_DFH;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef DFH_WALK_TIMEOUT_EN
    // Watchdog counts every cycle a request waits for accept or a read waits for data
    if ((csr_req_valid && csr_req_ready) || (rd_pend_q && csr_rsp_valid)) begin
      tmo_d = '0;
    end else if (csr_req_valid || rd_pend_q) begin
      tmo_d = tmo_q + 16'd1;
      if (tmo_d == 16'(TIMEOUT_CYC)) begin
        tmo_d       = '0;
        err_code_d  = 3'd4;
        err_addr_d  = csr_req_addr;
        req_valid_d = 1'b0;
        rd_pend_d   = 1'b0;
        fin_c       = 1'b1;
      end
    end
`endif

    // Status and done are registered on the same edge that leaves the deciding state
    if (fin_c) begin
      state_d = FIN;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = (err_code_d == 3'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      scr_addr_q    <= '0;
      next_off_q    <= '0;
      eol_q         <= 1'b0;
      rd_pend_q     <= 1'b0;
      guid_l_q      <= '0;
      guid_h_q      <= '0;
      rdback_q      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_code      <= '0;
      err_addr      <= '0;
      match_cnt     <= '0;
      feat_cnt      <= '0;
      csr_req_valid <= 1'b0;
      csr_req_write <= 1'b0;
      csr_req_addr  <= '0;
      csr_req_wdata <= '0;
`ifdef DFH_WALK_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      scr_addr_q    <= scr_addr_d;
      next_off_q    <= next_off_d;
      eol_q         <= eol_d;
      rd_pend_q     <= rd_pend_d;
      guid_l_q      <= guid_l_d;
      guid_h_q      <= guid_h_d;
      rdback_q      <= rdback_d;
      busy          <= busy_d;
      done          <= done_d;
      pass          <= pass_d;
      err_code      <= err_code_d;
      err_addr      <= err_addr_d;
      match_cnt     <= match_cnt_d;
      feat_cnt      <= feat_cnt_d;
      csr_req_valid <= req_valid_d;
      csr_req_write <= req_write_d;
      csr_req_addr  <= req_addr_d;
      csr_req_wdata <= req_wdata_d;
`ifdef DFH_WALK_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

endmodule
